// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: digest geometry, digest type, the digest-sink
// state encoding and the FIPS 180-4 initial hash words (also used by sha256_core).
package sha256_pkg;

  localparam int DIGEST_WORDS = 8;
  localparam int DIGEST_WIDTH = 256;

  typedef logic [DIGEST_WIDTH-1:0] digest_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } sink_state_e;

  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;

endpackage

// File: rtl/sha256_digest_sink_if.sv
// AXI-Stream digest-word channel.
//   master: drives tvalid/tkeep/tdata/tlast, observes tready
//   slave : observes tvalid/tkeep/tdata/tlast, drives tready
interface sha256_digest_sink_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tlast;

  modport master (output tvalid, tkeep, tdata, tlast, input tready);
  modport slave  (input tvalid, tkeep, tdata, tlast, output tready);
endinterface

// File: rtl/sha256_digest_sink.sv
// Terminates the sha256_core digest stream: collects one frame of digest
// words (first beat = most significant word), checks length and tkeep,
// compares against expected_digest and holds the result until digest_ack.
// Ports:
//   s_axis_aclk / s_axis_areset : clock, synchronous active-high reset
//   s_axis (slave)              : digest word stream
//   expected_digest             : reference digest, stable during the frame
//   digest / digest_valid       : assembled digest, held until digest_ack
//   match / err_len / err_keep  : frame result flags, valid with digest_valid
//   good_count                  : saturating count of matching frames
module sha256_digest_sink #(
  parameter int DATA_WIDTH   = 32,
  parameter int DIGEST_WORDS = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                               s_axis_aclk,
  input  logic                               s_axis_areset,
  sha256_digest_sink_if.slave                s_axis,
  input  logic [DATA_WIDTH*DIGEST_WORDS-1:0] expected_digest,
  output logic [DATA_WIDTH*DIGEST_WORDS-1:0] digest,
  output logic                               digest_valid,
  input  logic                               digest_ack,
  output logic                               match,
  output logic                               err_len,
  output logic                               err_keep,
  output logic [CNT_WIDTH-1:0]               good_count
);
  import sha256_pkg::*;

  localparam int                DW_TOT   = DATA_WIDTH * DIGEST_WORDS;
  localparam int                CNT_W    = $clog2(DIGEST_WORDS);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DIGEST_WORDS - 1);

  sink_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DW_TOT-1:0]     words_q, words_d;
  logic                  valid_q, valid_d;
  logic                  match_q, match_d;
  logic                  err_len_q, err_len_d;
  logic                  err_keep_q, err_keep_d;
  logic [CNT_WIDTH-1:0]  good_q, good_d;
  logic                  tready_q, tready_d;

  logic                  beat;
  logic                  keep_next;
  logic                  eq_next;
  logic [DW_TOT-1:0]     assembled;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    valid_d    = valid_q;
    match_d    = match_q;
    err_len_d  = err_len_q;
    err_keep_d = err_keep_q;
    good_d     = good_q;

    beat      = s_axis.tvalid && tready_q;
    keep_next = err_keep_q || (s_axis.tkeep != '1);

    // Stored words with the incoming beat dropped into its slot; slots not
    // yet received are still zero because storage is cleared between frames.
    assembled = words_q;
    for (int k = 0; k < DIGEST_WORDS; k++) begin
      if (cnt_q == k[CNT_W-1:0])
        assembled[DW_TOT-1-DATA_WIDTH*k -: DATA_WIDTH] = s_axis.tdata;
    end
    eq_next = (assembled == expected_digest);

    unique case (state_q)
      COLLECT: begin
        if (beat) begin
          words_d    = assembled;
          cnt_d      = cnt_q + 1'b1;
          err_keep_d = keep_next;
          if (s_axis.tlast) begin
            state_d   = DONE;
            valid_d   = 1'b1;
            err_len_d = (cnt_q != LAST_IDX);
            match_d   = eq_next && (cnt_q == LAST_IDX) && !keep_next;
            if (match_d && (good_q != '1))
              good_d = good_q + 1'b1;
          end else if (cnt_q == LAST_IDX) begin
            state_d   = DRAIN;
            err_len_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Overlong frame: swallow beats up to tlast, never a match.
        if (beat) begin
          err_keep_d = keep_next;
          if (s_axis.tlast) begin
            state_d = DONE;
            valid_d = 1'b1;
            match_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (digest_ack) begin
          state_d    = COLLECT;
          valid_d    = 1'b0;
          cnt_d      = '0;
          words_d    = '0;
          match_d    = 1'b0;
          err_len_d  = 1'b0;
          err_keep_d = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Drops on the edge that enters DONE; rises one cycle after leaving it.
    tready_d = (state_d != DONE) && (state_q != DONE);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      words_q    <= '0;
      valid_q    <= 1'b0;
      match_q    <= 1'b0;
      err_len_q  <= 1'b0;
      err_keep_q <= 1'b0;
      good_q     <= '0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      valid_q    <= valid_d;
      match_q    <= match_d;
      err_len_q  <= err_len_d;
      err_keep_q <= err_keep_d;
      good_q     <= good_d;
      tready_q   <= tready_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign digest        = words_q;
  assign digest_valid  = valid_q;
  assign match         = match_q;
  assign err_len       = err_len_q;
  assign err_keep      = err_keep_q;
  assign good_count    = good_q;

endmodule

// File: tb/tb_sha256_digest_sink.sv
module tb_sha256_digest_sink;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] expected_digest;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ack;
  logic         match, err_len, err_keep;
  logic [15:0]  good_count;

  int checks = 0;
  int passed = 0;

  sha256_digest_sink_if #(.DATA_WIDTH(32)) axis ();

  sha256_digest_sink #(.DATA_WIDTH(32), .DIGEST_WORDS(8), .CNT_WIDTH(16)) dut (
    .s_axis_aclk     (clk),
    .s_axis_areset   (rst),
    .s_axis          (axis),
    .expected_digest (expected_digest),
    .digest          (digest),
    .digest_valid    (digest_valid),
    .digest_ack      (digest_ack),
    .match           (match),
    .err_len         (err_len),
    .err_keep        (err_keep),
    .good_count      (good_count)
  );

  always #5 clk = ~clk;

  logic [31:0] abc_w [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                             32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [255:0] abc_digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  typedef struct {
    string        name;
    int           nbeats;
    int           keep_beat;   // beat index carrying tkeep=7, -1 for none
    bit           flip;        // expected digest has bit 0 inverted
    bit           gaps;        // random idle cycles between beats
    logic [255:0] exp_digest;
    logic         exp_match;
    logic         exp_elen;
    logic         exp_ekeep;
    logic [15:0]  exp_good;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] beat_data(input int i);
    return (i < 8) ? abc_w[i] : (32'hdead0000 + 32'(i));
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int guard = 0;
    axis.tvalid = 1'b1; axis.tdata = d; axis.tkeep = k; axis.tlast = l;
    while (!axis.tready && guard < 100) begin tick(); guard++; end
    if (guard >= 100) check("tready_timeout", 256'(axis.tready), 256'd1);
    tick();
    axis.tvalid = 1'b0; axis.tlast = 1'b0;
  endtask

  task automatic send_frame(input int n, input int keep_beat, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      send_beat(beat_data(i), (i == keep_beat) ? 4'h7 : 4'hF, i == n - 1);
    end
  endtask

  task automatic ack_and_check(input string tag);
    digest_ack = 1'b1; tick(); digest_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 256'(digest_valid), 256'd0);
    check({tag, "_tready_ack_cycle"}, 256'(axis.tready), 256'd0);
    tick();
    check({tag, "_tready_after_ack"}, 256'(axis.tready), 256'd1);
  endtask

  initial begin
    logic [255:0] short_mask;
    short_mask = {160'h0, 96'h0};
    short_mask = ~short_mask;
    short_mask[95:0] = '0;

    vecs[0] = '{"good",     8, -1, 0, 0, abc_digest,              1'b1, 1'b0, 1'b0, 16'd1};
    vecs[1] = '{"flip",     8, -1, 1, 0, abc_digest,              1'b0, 1'b0, 1'b0, 16'd1};
    vecs[2] = '{"good2",    8, -1, 0, 0, abc_digest,              1'b1, 1'b0, 1'b0, 16'd2};
    vecs[3] = '{"short5",   5, -1, 0, 0, abc_digest & short_mask, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[4] = '{"long10",  10, -1, 0, 0, abc_digest,              1'b0, 1'b1, 1'b0, 16'd2};
    vecs[5] = '{"keep7",    8,  2, 0, 0, abc_digest,              1'b0, 1'b0, 1'b1, 16'd2};
    vecs[6] = '{"gaps",     8, -1, 0, 1, abc_digest,              1'b1, 1'b0, 1'b0, 16'd3};

    axis.tvalid = 1'b0; axis.tdata = '0; axis.tkeep = 4'hF; axis.tlast = 1'b0;
    digest_ack = 1'b0; expected_digest = abc_digest;
    rst = 1'b1;
    tick(); tick();
    check("rst_tready", 256'(axis.tready), 256'd0);
    check("rst_valid",  256'(digest_valid), 256'd0);
    check("rst_digest", digest, 256'd0);
    check("rst_flags",  256'({match, err_len, err_keep}), 256'd0);
    check("rst_good",   256'(good_count), 256'd0);
    rst = 1'b0;
    tick();
    check("tready_after_rst", 256'(axis.tready), 256'd1);

    // ack with nothing held is ignored
    digest_ack = 1'b1; tick(); digest_ack = 1'b0;
    check("stray_ack_valid",  256'(digest_valid), 256'd0);
    check("stray_ack_tready", 256'(axis.tready), 256'd1);

    for (int v = 0; v < 7; v++) begin
      expected_digest = vecs[v].flip ? (abc_digest ^ 256'd1) : abc_digest;
      send_frame(vecs[v].nbeats, vecs[v].keep_beat, vecs[v].gaps);
      check({vecs[v].name, "_valid"},    256'(digest_valid), 256'd1);
      check({vecs[v].name, "_digest"},   digest, vecs[v].exp_digest);
      check({vecs[v].name, "_match"},    256'(match), 256'(vecs[v].exp_match));
      check({vecs[v].name, "_err_len"},  256'(err_len), 256'(vecs[v].exp_elen));
      check({vecs[v].name, "_err_keep"}, 256'(err_keep), 256'(vecs[v].exp_ekeep));
      check({vecs[v].name, "_good"},     256'(good_count), 256'(vecs[v].exp_good));
      check({vecs[v].name, "_tready"},   256'(axis.tready), 256'd0);
      // result holds while unacknowledged
      tick(); tick();
      check({vecs[v].name, "_hold"}, 256'({digest_valid, match}), 256'({1'b1, vecs[v].exp_match}));
      ack_and_check(vecs[v].name);
    end

    // reset in the middle of a frame
    expected_digest = abc_digest;
    for (int i = 0; i < 4; i++) send_beat(abc_w[i], 4'hF, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_tready", 256'(axis.tready), 256'd0);
    check("midrst_valid",  256'(digest_valid), 256'd0);
    check("midrst_digest", digest, 256'd0);
    check("midrst_good",   256'(good_count), 256'd0);
    rst = 1'b0;
    tick();
    check("midrst_tready_after", 256'(axis.tready), 256'd1);
    send_frame(8, -1, 0);
    check("post_rst_valid",  256'(digest_valid), 256'd1);
    check("post_rst_digest", digest, abc_digest);
    check("post_rst_match",  256'({match, err_len, err_keep}), 256'b100);
    check("post_rst_good",   256'(good_count), 256'd1);
    ack_and_check("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d", passed, checks);
    $fatal(1);
  end
endmodule
